// File: rtl/t02_instr_encoder.sv
// t02_instr_encoder: encodes control-unit operations into RV32I words and queues them with write addresses
// Ports: clk/rst (async active-high); in_valid/in_ready/in_cuOP/in_rd/in_rs1/in_rs2/in_imm operation input;
// load_base/base_addr load the write-address counter; out_valid/out_ready/out_instr/out_addr encoded word output;
// err sticky flag for unencodable operations; enc_count number of words enqueued.
module t02_instr_encoder (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [5:0]  in_cuOP,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic [19:0] in_imm,
  input  logic        load_base,
  input  logic [31:0] base_addr,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_addr,
  output logic        err,
  output logic [15:0] enc_count
);
  localparam logic [2:0] FU = 3'd0, FI = 3'd1, FSH = 3'd2, FS = 3'd3, FR = 3'd4, FX = 3'd5;
  logic [19:0] ctl;
  logic [2:0]  fmt;
  logic [6:0]  op, f7;
  logic [2:0]  f3;
  logic [31:0] instr, cur_addr, addr_cnt;
  logic [63:0] mem [2];
  logic        wp, rp, legal, acc, push, pop;
  logic [1:0]  cnt;
  // ctl = {format, opcode, funct3, funct7}; slot 21 and everything above AND is unencodable
  always_comb begin
    ctl = {FX, 7'h00, 3'b000, 7'h00};
    case (in_cuOP)
      6'd0:  ctl = {FU,  7'h37, 3'b000, 7'h00};
      6'd1:  ctl = {FU,  7'h17, 3'b000, 7'h00};
      6'd2:  ctl = {FU,  7'h6f, 3'b000, 7'h00};
      6'd3:  ctl = {FI,  7'h67, 3'b000, 7'h00};
      6'd4:  ctl = {FS,  7'h63, 3'b000, 7'h00};
      6'd5:  ctl = {FS,  7'h63, 3'b001, 7'h00};
      6'd6:  ctl = {FS,  7'h63, 3'b100, 7'h00};
      6'd7:  ctl = {FS,  7'h63, 3'b101, 7'h00};
      6'd8:  ctl = {FS,  7'h63, 3'b110, 7'h00};
      6'd9:  ctl = {FS,  7'h63, 3'b111, 7'h00};
      6'd10: ctl = {FI,  7'h03, 3'b000, 7'h00};
      6'd11: ctl = {FI,  7'h03, 3'b001, 7'h00};
      6'd12: ctl = {FI,  7'h03, 3'b010, 7'h00};
      6'd13: ctl = {FI,  7'h03, 3'b100, 7'h00};
      6'd14: ctl = {FI,  7'h03, 3'b101, 7'h00};
      6'd15: ctl = {FS,  7'h23, 3'b000, 7'h00};
      6'd16: ctl = {FS,  7'h23, 3'b001, 7'h00};
      6'd17: ctl = {FS,  7'h23, 3'b010, 7'h00};
      6'd18: ctl = {FI,  7'h13, 3'b000, 7'h00};
      6'd19: ctl = {FI,  7'h13, 3'b010, 7'h00};
      6'd20: ctl = {FI,  7'h13, 3'b011, 7'h00};
      6'd22: ctl = {FI,  7'h13, 3'b100, 7'h00};
      6'd23: ctl = {FI,  7'h13, 3'b110, 7'h00};
      6'd24: ctl = {FI,  7'h13, 3'b111, 7'h00};
      6'd25: ctl = {FSH, 7'h13, 3'b001, 7'h00};
      6'd26: ctl = {FSH, 7'h13, 3'b101, 7'h00};
      6'd27: ctl = {FSH, 7'h13, 3'b101, 7'h20};
      6'd28: ctl = {FR,  7'h33, 3'b000, 7'h00};
      6'd29: ctl = {FR,  7'h33, 3'b000, 7'h20};
      6'd30: ctl = {FR,  7'h33, 3'b001, 7'h00};
      6'd31: ctl = {FR,  7'h33, 3'b010, 7'h00};
      6'd32: ctl = {FR,  7'h33, 3'b011, 7'h00};
      6'd33: ctl = {FR,  7'h33, 3'b100, 7'h00};
      6'd34: ctl = {FR,  7'h33, 3'b101, 7'h00};
      6'd35: ctl = {FR,  7'h33, 3'b101, 7'h20};
      6'd36: ctl = {FR,  7'h33, 3'b110, 7'h00};
      6'd37: ctl = {FR,  7'h33, 3'b111, 7'h00};
      default: ctl = {FX, 7'h00, 3'b000, 7'h00};
    endcase
  end
  assign {fmt, op, f3, f7} = ctl;
  assign legal = fmt != FX;
  // branches share the store layout because the control unit already emits the split immediate
  assign instr = fmt == FU  ? {in_imm, in_rd, op} :
                 fmt == FI  ? {in_imm[11:0], in_rs1, f3, in_rd, op} :
                 fmt == FSH ? {f7, in_imm[4:0], in_rs1, f3, in_rd, op} :
                 fmt == FS  ? {in_imm[11:5], in_rs2, in_rs1, f3, in_imm[4:0], op} :
                 fmt == FR  ? {f7, in_rs2, in_rs1, f3, in_rd, op} : 32'h0;
  assign in_ready  = cnt != 2'd2;
  assign out_valid = cnt != 2'd0;
  assign {out_instr, out_addr} = mem[rp];
  assign acc  = in_valid && in_ready;
  assign push = acc && legal;
  assign pop  = out_valid && out_ready;
  // a same-cycle base load is visible to the word pushed in that cycle
  assign cur_addr = load_base ? {base_addr[31:2], 2'b00} : addr_cnt;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem[0]    <= '0;
      mem[1]    <= '0;
      wp        <= 1'b0;
      rp        <= 1'b0;
      cnt       <= 2'd0;
      addr_cnt  <= '0;
      enc_count <= '0;
      err       <= 1'b0;
    end else begin
      if (push) begin
        mem[wp]   <= {instr, cur_addr};
        wp        <= ~wp;
        enc_count <= enc_count + 16'd1;
      end
      if (pop) rp <= ~rp;
      cnt      <= cnt + {1'b0, push} - {1'b0, pop};
      addr_cnt <= push ? cur_addr + 32'd4 : cur_addr;
      err      <= err | (acc && !legal);
    end
  end
endmodule

// File: tb/tb_t02_instr_encoder.sv
// tb_t02_instr_encoder: randomized and directed checks of t02_instr_encoder against a table-driven model
module tb_t02_instr_encoder;
  logic        clk = 1'b0, rst = 1'b1, in_valid = 1'b0, in_ready, load_base = 1'b0;
  logic        out_valid, out_ready = 1'b0, err;
  logic [5:0]  in_cuOP = '0;
  logic [4:0]  in_rd = '0, in_rs1 = '0, in_rs2 = '0;
  logic [19:0] in_imm = '0;
  logic [31:0] base_addr = '0, out_instr, out_addr;
  logic [15:0] enc_count;
  int n_tests = 0, n_fail = 0;
  int fmt_t [64], opc_t [64], f3_t [64], f7_t [64];
  int br_f3 [6] = '{0, 1, 4, 5, 6, 7};
  int ld_f3 [5] = '{0, 1, 2, 4, 5};
  int oi_op [6] = '{18, 19, 20, 22, 23, 24};
  int oi_f3 [6] = '{0, 2, 3, 4, 6, 7};
  int r_f3 [10] = '{0, 0, 1, 2, 3, 4, 5, 5, 6, 7};
  bit [63:0]   q [$];
  bit [31:0]   m_addr = 0;
  bit [15:0]   m_cnt = 0;
  bit          m_err = 0;

  t02_instr_encoder dut (.clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_cuOP(in_cuOP),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm), .load_base(load_base),
    .base_addr(base_addr), .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_addr(out_addr), .err(err), .enc_count(enc_count));

  always #5 clk = ~clk;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // formats: 0 U, 1 I, 2 shift-imm, 3 S/B, 4 R, 5 illegal
  function automatic bit [31:0] ref_enc(int o, int rd, int rs1, int rs2, int imm);
    longint r;
    case (fmt_t[o])
      0: r = longint'(imm) * 4096 + rd * 128 + opc_t[o];
      1: r = longint'(imm % 4096) * (1 << 20) + rs1 * (1 << 15) + f3_t[o] * 4096 + rd * 128 + opc_t[o];
      2: r = longint'(f7_t[o]) * (1 << 25) + (imm % 32) * (1 << 20) + rs1 * (1 << 15) + f3_t[o] * 4096 + rd * 128 + opc_t[o];
      3: r = longint'((imm / 32) % 128) * (1 << 25) + rs2 * (1 << 20) + rs1 * (1 << 15) + f3_t[o] * 4096 + (imm % 32) * 128 + opc_t[o];
      4: r = longint'(f7_t[o]) * (1 << 25) + rs2 * (1 << 20) + rs1 * (1 << 15) + f3_t[o] * 4096 + rd * 128 + opc_t[o];
      default: r = 0;
    endcase
    return r[31:0];
  endfunction

  task automatic check_all(string tag);
    chk({tag, "_in_ready"}, 32'(in_ready), 32'(q.size() < 2));
    chk({tag, "_out_valid"}, 32'(out_valid), 32'(q.size() > 0));
    if (q.size() > 0) begin
      chk({tag, "_instr"}, out_instr, q[0][63:32]);
      chk({tag, "_addr"}, out_addr, q[0][31:0]);
    end
    chk({tag, "_err"}, 32'(err), 32'(m_err));
    chk({tag, "_count"}, 32'(enc_count), 32'(m_cnt));
  endtask

  task automatic cyc(string tag);
    bit acc, pop, lg;
    bit [31:0] nb, w;
    acc = in_valid && q.size() < 2;
    pop = out_ready && q.size() > 0;
    lg  = fmt_t[in_cuOP] != 5;
    nb  = load_base ? (base_addr & ~32'h3) : m_addr;
    w   = ref_enc(int'(in_cuOP), int'(in_rd), int'(in_rs1), int'(in_rs2), int'(in_imm));
    @(posedge clk);
    #1;
    if (pop) void'(q.pop_front());
    if (acc && lg) begin
      q.push_back({w, nb});
      m_addr = nb + 32'd4;
      m_cnt++;
    end else m_addr = nb;
    if (acc && !lg) m_err = 1;
    check_all(tag);
  endtask

  task automatic set_op(int o, int rd, int rs1, int rs2, int imm);
    in_cuOP = 6'(o); in_rd = 5'(rd); in_rs1 = 5'(rs1); in_rs2 = 5'(rs2); in_imm = 20'(imm);
  endtask

  task automatic model_reset();
    q.delete(); m_addr = 0; m_cnt = 0; m_err = 0;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) begin fmt_t[i] = 5; opc_t[i] = 0; f3_t[i] = 0; f7_t[i] = 0; end
    fmt_t[0] = 0; opc_t[0] = 'h37;
    fmt_t[1] = 0; opc_t[1] = 'h17;
    fmt_t[2] = 0; opc_t[2] = 'h6f;
    fmt_t[3] = 1; opc_t[3] = 'h67;
    for (int i = 0; i < 6; i++) begin fmt_t[4 + i] = 3; opc_t[4 + i] = 'h63; f3_t[4 + i] = br_f3[i]; end
    for (int i = 0; i < 5; i++) begin fmt_t[10 + i] = 1; opc_t[10 + i] = 'h03; f3_t[10 + i] = ld_f3[i]; end
    for (int i = 0; i < 3; i++) begin fmt_t[15 + i] = 3; opc_t[15 + i] = 'h23; f3_t[15 + i] = i; end
    for (int i = 0; i < 6; i++) begin fmt_t[oi_op[i]] = 1; opc_t[oi_op[i]] = 'h13; f3_t[oi_op[i]] = oi_f3[i]; end
    for (int i = 25; i < 28; i++) begin fmt_t[i] = 2; opc_t[i] = 'h13; end
    f3_t[25] = 1; f3_t[26] = 5; f3_t[27] = 5; f7_t[27] = 'h20;
    for (int i = 0; i < 10; i++) begin fmt_t[28 + i] = 4; opc_t[28 + i] = 'h33; f3_t[28 + i] = r_f3[i]; end
    f7_t[29] = 'h20; f7_t[35] = 'h20;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_instr", out_instr, 32'h0);
    chk("rst_out_addr", out_addr, 32'h0);
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    rst = 1'b0;
    #1;
    check_all("rst");
    // ADDI x5, x1, 0xFFF
    out_ready = 1'b1; in_valid = 1'b1; set_op(18, 5, 1, 0, 'hFFF);
    cyc("addi");
    chk("addi_word", out_instr, 32'hFFF08293);
    chk("addi_at", out_addr, 32'h0);
    in_valid = 1'b0;
    cyc("drain0");
    // base load with SW then SUB
    out_ready = 1'b0; in_valid = 1'b1; load_base = 1'b1; base_addr = 32'h100; set_op(17, 0, 2, 3, 8);
    cyc("sw");
    load_base = 1'b0; set_op(29, 1, 2, 3, 0);
    cyc("sub");
    in_valid = 1'b0;
    chk("sw_word", out_instr, 32'h00312423);
    chk("sw_at", out_addr, 32'h100);
    out_ready = 1'b1;
    cyc("pop_sw");
    chk("sub_word", out_instr, 32'h403100B3);
    chk("sub_at", out_addr, 32'h104);
    cyc("pop_sub");
    // backpressure: three offered, two taken
    out_ready = 1'b0; in_valid = 1'b1; set_op(28, 7, 8, 9, 0);
    cyc("bp1");
    cyc("bp2");
    chk("bp_full", 32'(in_ready), 32'h0);
    cyc("bp3");
    in_valid = 1'b0; out_ready = 1'b1;
    cyc("bp_pop");
    chk("bp_ready_again", 32'(in_ready), 32'h1);
    cyc("bp_drain");
    // illegal op sets sticky err
    in_valid = 1'b1; set_op(38, 1, 1, 1, 1);
    cyc("ill");
    in_valid = 1'b0;
    chk("ill_err", 32'(err), 32'h1);
    chk("ill_no_valid", 32'(out_valid), 32'h0);
    cyc("ill_hold");
    // address wrap
    in_valid = 1'b1; load_base = 1'b1; base_addr = 32'hFFFFFFFE; set_op(18, 1, 1, 0, 1);
    cyc("wrap1");
    chk("wrap_first", out_addr, 32'hFFFFFFFC);
    load_base = 1'b0;
    cyc("wrap2");
    in_valid = 1'b0;
    chk("wrap_second", out_addr, 32'h0);
    cyc("wrap_drain");
    // reset with two words buffered
    out_ready = 1'b0; in_valid = 1'b1; set_op(0, 3, 0, 0, 'hABCDE);
    cyc("fill1");
    cyc("fill2");
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1 chk("rst_mid_valid", 32'(out_valid), 32'h0);
    model_reset();
    @(posedge clk);
    #3 rst = 1'b0;
    #1 chk("rst_mid_ready", 32'(in_ready), 32'h1);
    check_all("post_rst");
    cyc("post_rst_cyc");
    // random traffic
    for (int n = 0; n < 600; n++) begin
      in_valid  = 1'($urandom_range(0, 3) != 0);
      out_ready = 1'($urandom_range(0, 2) != 0);
      load_base = 1'($urandom_range(0, 15) == 0);
      base_addr = ($urandom_range(0, 3) == 0) ? (32'hFFFFFFF0 | 32'($urandom_range(0, 15))) : $urandom;
      set_op(($urandom_range(0, 15) == 0) ? $urandom_range(0, 63) : $urandom_range(0, 37),
             $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 'hFFFFF));
      cyc("rnd");
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/t02_instr_encoder.md
T02_INSTR_ENCODER -- requirements
Module: t02_instr_encoder

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-high reset, with ports named clk and rst.
REQ-002 Port: clk  in  1  system clock; all state updates on the rising edge.
REQ-003 Port: rst  in  1  asynchronous active-high reset.
REQ-004 Port: in_valid  in  1  producer presents an operation.
REQ-005 Port: in_ready  out  1  block can accept; transfer occurs when in_valid && in_ready at a rising edge.
REQ-006 Port: in_cuOP  in  6  operation code, same numbering as the team control-unit enumeration (LUI=0 ... AND=37, ERROR=38).
REQ-007 Port: in_rd, in_rs1, in_rs2  in  5 each  destination and source register indices.
REQ-008 Port: in_imm  in  20  immediate, in the field layout the control unit emits.
REQ-009 Port: load_base, base_addr  in  1, 32  synchronous load of the write-address counter.
REQ-010 Port: out_valid  out  1  encoded word available.
REQ-011 Port: out_ready  in  1  consumer (instruction-memory writer) accepts; the word is popped when out_valid && out_ready.
REQ-012 Port: out_instr, out_addr  out  32, 32  RV32I instruction word and its target byte address.
REQ-013 Port: err  out  1  sticky flag, set when an unencodable operation is accepted.
REQ-014 Port: enc_count  out  16  number of words enqueued, wrapping at 0xFFFF to 0.

Function
REQ-015 Encoding SHALL be standard RV32I: U/J (LUI 0110111, AUIPC 0010111, JAL 1101111): instr[31:12]=in_imm, instr[11:7]=rd.
REQ-016 JALR, loads (0000011), and OP-IMM (0010011) SHALL place in_imm[11:0] at [31:20], rs1 at [19:15], rd at [11:7], funct3 per RV32I (LB 000, LH 001, LW 010, LBU 100, LHU 101; ADDI 000, SLTI 010, SLTIU 011, XORI 100, ORI 110, ANDI 111).
REQ-017 SLLI/SRLI SHALL emit funct7 0000000 and SRAI funct7 0100000, with shamt=in_imm[4:0] at [24:20] and funct3 001/101/101.
REQ-018 Stores (0100011, SB 000, SH 001, SW 010) and branches (1100011, BEQ 000, BNE 001, BLT 100, BGE 101, BLTU 110, BGEU 111) SHALL place in_imm[11:5] at [31:25], in_imm[4:0] at [11:7], rs2 at [24:20], rs1 at [19:15].
REQ-019 R-type (0110011) SHALL use funct3 ADD/SUB 000, SLL 001, SLT 010, SLTU 011, XOR 100, SRL/SRA 101, OR 110, AND 111, with funct7 0100000 for SUB and SRA, else 0000000.
REQ-020 cuOP 21, 38 and 39-63 SHALL be illegal: accepted (handshake completes), not enqueued, err set from the next cycle, enc_count and the address counter unchanged.
REQ-021 Output buffering SHALL be a 2-entry FIFO of {instr, addr}; in_ready = (occupancy < 2), independent of in_valid.
REQ-022 Latency: a word accepted at edge N SHALL be presented with out_valid=1 after edge N if the FIFO was empty; words SHALL leave in acceptance order.
REQ-023 A simultaneous push and pop SHALL leave occupancy unchanged; a pop with FIFO full SHALL raise in_ready on the next cycle; there is no combinational path from out_ready to in_ready.
REQ-024 out_instr/out_addr SHALL hold stable while out_valid=1 and out_ready=0.
REQ-025 Each enqueued word SHALL take out_addr = address counter, and the counter SHALL advance by 4, wrapping 0xFFFFFFFC to 0x00000000.
REQ-026 load_base SHALL load the counter with {base_addr[31:2],2'b00}; if a push occurs in the same cycle, the pushed word SHALL take the new base, and the counter SHALL become base+4.

Reset
REQ-027 On rst: FIFO empty, out_valid=0, in_ready=1 after reset deassertion, out_instr=0, out_addr=0, address counter=0, enc_count=0, err=0.
REQ-028 Assertion of rst mid-transfer SHALL discard all buffered words immediately, without completing the handshake.

Verification
REQ-029 ADDI rd=5 rs1=1 imm=0x00FFF, out_ready=1 -> next cycle out_valid=1, out_instr=0xFFF08293, out_addr=0.
REQ-030 load_base=1 base_addr=0x100 with pushes of SW rs1=2 rs2=3 imm=8 and then SUB rd=1 rs1=2 rs2=3 -> 0x00312423 @0x100, then 0x403100B3 @0x104.
REQ-031 out_ready=0 with 3 pushes -> in_ready=0 after 2 pushes; then out_ready=1 for one cycle -> one pop and in_ready=1 on the next cycle.
REQ-032 cuOP=38 pushed -> err=1 on the following cycle and held, no out_valid, enc_count unchanged.
REQ-033 base_addr=0xFFFFFFFC with two pushes -> out_addr values 0xFFFFFFFC, then 0x00000000.
REQ-034 rst asserted with 2 words buffered -> out_valid=0 immediately, and in_ready=1 after deassertion.
